// File: rtl/op_pkg.sv
// rtl/op_pkg.sv - shared operation encodings and executor state type
package op_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic logic is_valid_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative shift-add multiplier / restoring divider
module muldiv_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // acc: product accumulator (MUL) or partial remainder in low bits (DIV)
  // opnd: shifting multiplicand (MUL) or divisor in low bits (DIV)
  // shreg: multiplier bits (MUL) or dividend-in / quotient-out (DIV)
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    shifted  = {acc_q[WIDTH-1:0], shreg_q[WIDTH-1]};
    diff     = shifted - {1'b0, opnd_q[WIDTH-1:0]};
    ge       = shifted >= {1'b0, opnd_q[WIDTH-1:0]};
    rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {shreg_q[WIDTH-2:0], ge};
    mul_next = acc_q + (shreg_q[0] ? opnd_q : '0);

    // Value after the current step, so the caller can latch it on the last one
    result = mode ? {rem_next, quo_next} : mul_next;
    last   = (cnt_q == CW'(WIDTH - 1));

    acc_d   = acc_q;
    opnd_d  = opnd_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (start) begin
      acc_d   = '0;
      opnd_d  = {{WIDTH{1'b0}}, b};
      shreg_d = a;
      cnt_d   = '0;
    end else if (step) begin
      if (mode) begin
        acc_d   = {{WIDTH{1'b0}}, rem_next};
        shreg_d = quo_next;
      end else begin
        acc_d   = mul_next;
        opnd_d  = {opnd_q[2*WIDTH-2:0], 1'b0};
        shreg_d = shreg_q >> 1;
      end
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      opnd_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pulse.sv
// rtl/pulse.sv - rising-edge detector; one-cycle pulse per low-to-high select
module pulse (
  input  logic clk,
  input  logic reset,
  input  logic select,
  output logic pulse_out
);

  logic sel_q, sel_d;
  logic prev_q, prev_d;

  always_comb begin
    sel_d  = select;
    prev_d = sel_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      prev_q <= prev_d;
    end
  end

  assign pulse_out = sel_q & ~prev_q;

endmodule

// File: rtl/op_executor.sv
// rtl/op_executor.sv - captures a one-hot operation and operands, runs it, holds the result
module op_executor
  import op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               execute,
  input  logic [3:0]         operation,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               error
);

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               start_p;
  logic               seq_start;
  logic               seq_step;
  logic               seq_mode;
  logic [2*WIDTH-1:0] seq_result;
  logic               seq_last;

  pulse u_pulse (
    .clk       (clk),
    .reset     (reset),
    .select    (execute),
    .pulse_out (start_p)
  );

  // Loaded from the live operands on the capture edge, same values as a_q/b_q
  muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk    (clk),
    .reset  (reset),
    .start  (seq_start),
    .mode   (seq_mode),
    .step   (seq_step),
    .a      (a),
    .b      (b),
    .result (seq_result),
    .last   (seq_last)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    seq_start = 1'b0;
    seq_step  = 1'b0;
    seq_mode  = (op_q == OP_DIV);

    case (state_q)
      IDLE: begin
        if (start_p) begin
          op_d    = operation;
          a_d     = a;
          b_d     = b;
          error_d = 1'b0;
          busy_d  = 1'b1;
          if (is_valid_op(operation)) begin
            state_d   = CALC;
            seq_start = (operation == OP_MUL) || (operation == OP_DIV);
          end else begin
            state_d  = DONE;
            result_d = '0;
            error_d  = 1'b1;
            done_d   = 1'b1;
          end
        end
      end
      CALC: begin
        if (op_q == OP_ADD) begin
          result_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
          state_d  = DONE;
          done_d   = 1'b1;
        end else if (op_q == OP_SUB) begin
          result_d = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
          state_d  = DONE;
          done_d   = 1'b1;
        end else if (op_q == OP_DIV && b_q == '0) begin
          result_d = '1;
          error_d  = 1'b1;
          state_d  = DONE;
          done_d   = 1'b1;
        end else if (op_q == OP_MUL || op_q == OP_DIV) begin
          seq_step = 1'b1;
          if (seq_last) begin
            result_d = seq_result;
            state_d  = DONE;
            done_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;

endmodule

// File: tb/tb_op_executor.sv
// tb/tb_op_executor.sv - directed self-checking bench for op_executor
module tb_op_executor;

  logic       clk;
  logic       reset;
  logic       execute;
  logic [3:0] operation;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] result;
  logic       busy;
  logic       done;
  logic       error;

  int n_vec;
  int n_miss;

  op_executor #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .execute   (execute),
    .operation (operation),
    .a         (a),
    .b         (b),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press execute and count edges (from the first sampling edge) until done
  task automatic do_op(input string tag, input logic [3:0] op, input logic [3:0] ia,
                       input logic [3:0] ib, input logic [7:0] exp_res, input logic exp_err,
                       input int exp_lat, input int exp_busy);
    int lat;
    int bc;
    logic [7:0] res;
    logic err;
    logic seen;
    operation = op;
    a = ia;
    b = ib;
    execute = 1'b1;
    lat = 0;
    bc = 0;
    seen = 1'b0;
    res = '0;
    err = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (busy) bc++;
      if (done) begin
        seen = 1'b1;
        res = result;
        err = error;
      end else if (lat == 2) begin
        operation = ~op;
        a = ~ia;
        b = ib + 4'd3;
      end
    end
    execute = 1'b0;
    check({tag, ".done_seen"}, seen, 1);
    check({tag, ".result"}, res, exp_res);
    check({tag, ".error"}, err, exp_err);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, bc, exp_busy);
    tick();
    check({tag, ".done_one_cycle"}, done, 0);
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".result_held"}, result, exp_res);
  endtask

  initial begin
    int dones;
    logic [7:0] res;
    n_vec = 0;
    n_miss = 0;
    reset = 1'b1;
    execute = 1'b0;
    operation = 4'b0000;
    a = '0;
    b = '0;
    repeat (3) tick();
    check("reset.result", result, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.error", error, 0);
    reset = 1'b0;
    tick();

    do_op("add_9_8",   4'b0001, 4'd9,  4'd8,  8'h11, 1'b0, 3, 2);
    do_op("sub_3_5",   4'b0010, 4'd3,  4'd5,  8'hFE, 1'b0, 3, 2);
    do_op("mul_15_15", 4'b0100, 4'd15, 4'd15, 8'hE1, 1'b0, 6, 5);
    do_op("mul_6_7",   4'b0100, 4'd6,  4'd7,  8'h2A, 1'b0, 6, 5);
    do_op("div_13_4",  4'b1000, 4'd13, 4'd4,  8'h13, 1'b0, 6, 5);
    do_op("div_3_7",   4'b1000, 4'd3,  4'd7,  8'h30, 1'b0, 6, 5);
    do_op("div_15_15", 4'b1000, 4'd15, 4'd15, 8'h01, 1'b0, 6, 5);
    do_op("div_7_0",   4'b1000, 4'd7,  4'd0,  8'hFF, 1'b1, 3, 2);
    do_op("inv_0011",  4'b0011, 4'd5,  4'd6,  8'h00, 1'b1, 2, 1);
    do_op("inv_0000",  4'b0000, 4'd5,  4'd6,  8'h00, 1'b1, 2, 1);
    do_op("add_15_15", 4'b0001, 4'd15, 4'd15, 8'h1E, 1'b0, 3, 2);
    do_op("sub_0_15",  4'b0010, 4'd0,  4'd15, 8'hF1, 1'b0, 3, 2);

    // Execute held for 20 cycles: exactly one operation
    operation = 4'b0100;
    a = 4'd5;
    b = 4'd3;
    execute = 1'b1;
    dones = 0;
    res = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) begin
        dones++;
        res = result;
      end
      if (i == 19) execute = 1'b0;
    end
    check("hold.done_count", dones, 1);
    check("hold.result", res, 8'h0F);

    // Second press while busy is dropped
    operation = 4'b0100;
    a = 4'd2;
    b = 4'd3;
    dones = 0;
    res = '0;
    for (int i = 0; i < 30; i++) begin
      execute = (i < 2) || (i == 3) || (i == 4);
      if (i == 3) a = 4'd9;
      tick();
      if (done) begin
        dones++;
        res = result;
      end
    end
    check("repress.done_count", dones, 1);
    check("repress.result", res, 8'h06);

    // Reset during the second MUL iteration
    operation = 4'b0100;
    a = 4'd15;
    b = 4'd15;
    execute = 1'b1;
    repeat (3) tick();
    check("rst_mid.busy_before", busy, 1);
    check("rst_mid.result_before", result, 8'h06);
    reset = 1'b1;
    execute = 1'b0;
    #1;
    check("rst_mid.result", result, 0);
    check("rst_mid.busy", busy, 0);
    check("rst_mid.done", done, 0);
    check("rst_mid.error", error, 0);
    repeat (2) tick();
    reset = 1'b0;
    dones = 0;
    repeat (8) begin
      tick();
      if (done || busy) dones++;
    end
    check("rst_mid.no_activity", dones, 0);
    do_op("add_1_1", 4'b0001, 4'd1, 4'd1, 8'h02, 1'b0, 3, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
